pipe_ctrl_mw: RTL and testbench
===============================

Name: pipe_ctrl_mw

Overview:
- Parametrised pipeline control unit. Combines structure-full flags from the front and back ends with an N-wide in-order retire group.
- Generates freeze signals, a per-slot commit mask and a flush pulse for the oldest excepting retiring instruction.
- After a flush it holds a recovery window of FLUSH_CYC cycles, so that rename, ROB and queue state can rewind before fetch resumes.

Parameters:
- RET_W, 3, number of retire slots; slot 0 is oldest.
- FULL_N, 7, number of structure-full sources. Bit order: PRF, ROB, FIFO, RS_add, RS_mul, RS_agu, LSQ.
- BACK_MASK, 7'b0000100, FULL_N-bit mask selecting which full sources also freeze the back end.
- FLUSH_CYC, 2, recovery cycles after a flush pulse; legal range 1..15.
- SLOT_W, $clog2(RET_W) (minimum 1), width of the slot index.

Ports:
- clk, input, 1, single clock; all state on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- full_vec, input, FULL_N, structure-full flags, one per source.
- ready_ret, input, RET_W, slot i head instruction is complete.
- excep_ret, input, RET_W, slot i head instruction raised an exception; qualified by ready_ret[i].
- flush, output, 1, one-cycle flush pulse.
- excep_slot, output, SLOT_W, index of the slot that caused the flush; valid only while flush=1.
- commit_mask, output, RET_W, slots that retire this cycle.
- freeze_front, output, 1, stall fetch, decode and rename.
- freeze_back, output, 1, stall issue and execute.
- recovering, output, 1, high throughout the recovery window.

Behaviour:
- States: IDLE, RECOVER. A 4-bit down-counter rec_cnt runs in RECOVER.
- Reset while rst_n=0 (asynchronous, also mid-RECOVER):
  - state=IDLE, rec_cnt=0.
  - Outputs forced: flush=0, excep_slot=0, commit_mask=0, recovering=0, freeze_front=1, freeze_back=1.
  - The first cycle after deassertion is normal IDLE operation.
- Retirement prefix, combinational, IDLE only:
  - ok[i] = &ready_ret[i:0].
  - Exception candidate: the lowest i with ok[i] & excep_ret[i].
  - Exception bits on non-ready slots, or on slots behind a non-ready slot, are ignored.
- IDLE with no candidate:
  - commit_mask = ok; flush=0.
- IDLE with candidate k:
  - flush=1, excep_slot=k.
  - commit_mask has bits [k-1:0] set; the excepting slot k does not commit, nor do any younger slots.
  - Next state RECOVER, rec_cnt loaded with FLUSH_CYC.
- RECOVER:
  - flush=0, commit_mask=0, recovering=1. All retire inputs are ignored, including new exceptions.
  - rec_cnt decrements each cycle. When rec_cnt=1, next state is IDLE.
  - Exactly FLUSH_CYC cycles are spent in RECOVER.
- Freeze logic, outside reset:
  - freeze_front = (|full_vec) | recovering.
  - freeze_back = |(full_vec & BACK_MASK). It is not asserted by recovery, so the back end keeps draining.
- Latency:
  - flush, excep_slot and commit_mask are combinational from the same-cycle inputs.
  - recovering rises the cycle after flush.
- Back-to-back exceptions:
  - An exception present on the cycle RECOVER exits is evaluated normally in IDLE.
  - flush can therefore pulse again exactly FLUSH_CYC+1 cycles after the previous pulse.
- Simultaneous full flags and flush: both are reported. The flush is never masked by a freeze.
- RET_W=1 degenerates to single-slot behaviour: flush = ready_ret[0] & excep_ret[0].

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- With the macro defined, three extra outputs are added:
  - perf_front_stall, 32 bits: cycles with freeze_front=1 outside reset.
  - perf_back_stall, 32 bits: cycles with freeze_back=1 outside reset.
  - perf_flush, 32 bits: count of flush pulses.
- Counter rules with the macro: all three saturate at 32'hFFFFFFFF, reset to 0 on rst_n=0, and increment in the cycle after the counted event (registered).
- Without the macro: these ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset: hold rst_n=0 with ready_ret=3'b111, excep_ret=3'b001 -> flush=0, commit_mask=0, freeze_front=freeze_back=1. On release, flush=1 the same cycle.
- Clean retire:
  - ready_ret=3'b011, excep_ret=0 -> commit_mask=3'b011, flush=0.
  - ready_ret=3'b101 -> commit_mask=3'b001 (hole at slot 1).
- Mid-group exception: ready_ret=3'b111, excep_ret=3'b110 -> flush=1, excep_slot=1, commit_mask=3'b001. The next 2 cycles give recovering=1, freeze_front=1, commit_mask=0.
- Ignored exception: ready_ret=3'b101, excep_ret=3'b100 -> flush=0, commit_mask=3'b001.
- Recovery, FLUSH_CYC=2:
  - Excepting slot 0 held constantly -> flush pulses at cycles t, t+3, t+6.
  - Asserting rst_n=0 at t+1 -> recovering=0 immediately, and flush=1 again on the first cycle after release.
- Freeze masking: full_vec=7'b0000100 -> freeze_front=1, freeze_back=1. full_vec=7'b1000000 -> freeze_front=1, freeze_back=0. With PIPE_CTRL_PERF_EN, 10 cycles of the latter give perf_front_stall=10, perf_back_stall=0.

Source files
------------

// File: rtl/pipe_ctrl_mw.sv
// pipe_ctrl_mw: pipeline control unit combining structure-full flags with an
// RET_W-wide in-order retire group; produces freezes, commit mask and flush.
// Ports: clk, rst_n (async active-low), full_vec[FULL_N], ready_ret[RET_W],
//   excep_ret[RET_W] in; flush, excep_slot[SLOT_W], commit_mask[RET_W],
//   freeze_front, freeze_back, recovering out.
// Optional macro PIPE_CTRL_PERF_EN adds perf_front_stall, perf_back_stall,
//   perf_flush (32-bit saturating event counters).
module pipe_ctrl_mw #(
    parameter int RET_W = 3,
    parameter int FULL_N = 7,
    parameter logic [FULL_N-1:0] BACK_MASK = FULL_N'(7'b0000100),
    parameter int FLUSH_CYC = 2,
    parameter int SLOT_W = (RET_W > 1) ? $clog2(RET_W) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FULL_N-1:0] full_vec,
    input  logic [RET_W-1:0]  ready_ret,
    input  logic [RET_W-1:0]  excep_ret,
    output logic              flush,
    output logic [SLOT_W-1:0] excep_slot,
    output logic [RET_W-1:0]  commit_mask,
    output logic              freeze_front,
    output logic              freeze_back,
`ifdef PIPE_CTRL_PERF_EN
    output logic [31:0]       perf_front_stall,
    output logic [31:0]       perf_back_stall,
    output logic [31:0]       perf_flush,
`endif
    output logic              recovering
);

    typedef enum logic {
        IDLE,
        RECOVER
    } state_t;

    localparam logic [3:0] FC4 = 4'(FLUSH_CYC);

    state_t            state_q, state_d;
    logic [3:0]        rec_cnt_q, rec_cnt_d;
    logic [RET_W-1:0]  ok;
    logic [RET_W-1:0]  ret_mask;
    logic              cand;
    logic [SLOT_W-1:0] k_idx;
    logic              seen;

    // In-order retire prefix; the first ready excepting slot and everything
    // younger are held back from commit.
    always_comb begin
        ok       = '0;
        ret_mask = '0;
        cand     = 1'b0;
        k_idx    = '0;
        seen     = 1'b0;
        ok[0]    = ready_ret[0];
        for (int i = 1; i < RET_W; i++) begin
            ok[i] = ok[i-1] & ready_ret[i];
        end
        for (int i = 0; i < RET_W; i++) begin
            seen        = seen | (ok[i] & excep_ret[i]);
            ret_mask[i] = ok[i] & ~seen;
        end
        for (int i = RET_W - 1; i >= 0; i--) begin
            if (ok[i] & excep_ret[i]) begin
                cand  = 1'b1;
                k_idx = SLOT_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rec_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rec_cnt_q <= rec_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rec_cnt_d   = rec_cnt_q;
        flush       = 1'b0;
        excep_slot  = '0;
        commit_mask = '0;
        recovering  = 1'b0;
        unique case (state_q)
            IDLE: begin
                commit_mask = ret_mask;
                if (cand) begin
                    flush      = 1'b1;
                    excep_slot = k_idx;
                    state_d    = RECOVER;
                    rec_cnt_d  = FC4;
                end
            end
            RECOVER: begin
                recovering = 1'b1;
                rec_cnt_d  = rec_cnt_q - 4'd1;
                if (rec_cnt_q == 4'd1) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Outputs are forced while reset is held, even mid-recovery.
        if (!rst_n) begin
            flush       = 1'b0;
            excep_slot  = '0;
            commit_mask = '0;
            recovering  = 1'b0;
        end
    end

    // Recovery stalls only the front end so the back end can drain.
    assign freeze_front = ~rst_n | (|full_vec) | recovering;
    assign freeze_back  = ~rst_n | (|(full_vec & BACK_MASK));

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_front_stall <= '0;
            perf_back_stall  <= '0;
            perf_flush       <= '0;
        end else begin
            if (freeze_front && perf_front_stall != 32'hFFFF_FFFF) begin
                perf_front_stall <= perf_front_stall + 32'd1;
            end
            if (freeze_back && perf_back_stall != 32'hFFFF_FFFF) begin
                perf_back_stall <= perf_back_stall + 32'd1;
            end
            if (flush && perf_flush != 32'hFFFF_FFFF) begin
                perf_flush <= perf_flush + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl_mw.sv
// tb_pipe_ctrl_mw: scoreboard bench for pipe_ctrl_mw; driver pushes expected
// outputs from a behavioural model, monitor pops and compares each cycle.
module tb_pipe_ctrl_mw;

    localparam int RW = 3;
    localparam int FN = 7;
    localparam int FC = 2;
    localparam int SW = 2;
    localparam logic [FN-1:0] BM = 7'b0000100;

    logic          clk;
    logic          rst_n;
    logic [FN-1:0] full_vec;
    logic [RW-1:0] ready_ret;
    logic [RW-1:0] excep_ret;
    logic          flush;
    logic [SW-1:0] excep_slot;
    logic [RW-1:0] commit_mask;
    logic          freeze_front;
    logic          freeze_back;
    logic          recovering;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0]   perf_front_stall;
    logic [31:0]   perf_back_stall;
    logic [31:0]   perf_flush;
`endif

    pipe_ctrl_mw dut (
        .clk(clk),
        .rst_n(rst_n),
        .full_vec(full_vec),
        .ready_ret(ready_ret),
        .excep_ret(excep_ret),
        .flush(flush),
        .excep_slot(excep_slot),
        .commit_mask(commit_mask),
        .freeze_front(freeze_front),
        .freeze_back(freeze_back),
`ifdef PIPE_CTRL_PERF_EN
        .perf_front_stall(perf_front_stall),
        .perf_back_stall(perf_back_stall),
        .perf_flush(perf_flush),
`endif
        .recovering(recovering)
    );

    typedef struct packed {
        logic          fl;
        logic [SW-1:0] slot;
        logic [RW-1:0] mask;
        logic          ff;
        logic          fb;
        logic          rec;
        logic [31:0]   pf;
        logic [31:0]   pb;
        logic [31:0]   pfl;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   rem = 0;
    int   pf_acc = 0;
    int   pb_acc = 0;
    int   pfl_acc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h want %0h", name, $time, act, want);
        end
    endtask

    // Reference model: retire the ready prefix up to the first excepting
    // instruction; a flush opens a window of FC cycles ignoring retirement.
    task automatic step(input bit r, input logic [FN-1:0] fv,
                        input logic [RW-1:0] rd, input logic [RW-1:0] ex);
        exp_t e;
        int   n;
        int   k;
        @(posedge clk);
        #1;
        rst_n     = r;
        full_vec  = fv;
        ready_ret = rd;
        excep_ret = ex;
        e = '0;
        if (!r) begin
            rem = 0;
            pf_acc = 0;
            pb_acc = 0;
            pfl_acc = 0;
            e.ff = 1'b1;
            e.fb = 1'b1;
        end else begin
            e.pf  = 32'(pf_acc);
            e.pb  = 32'(pb_acc);
            e.pfl = 32'(pfl_acc);
            if (rem > 0) begin
                e.rec = 1'b1;
                rem--;
            end else begin
                n = 0;
                while (n < RW && rd[n]) n++;
                k = -1;
                for (int i = 0; i < n; i++) begin
                    if (ex[i] && k < 0) k = i;
                end
                if (k >= 0) begin
                    e.fl   = 1'b1;
                    e.slot = SW'(k);
                    for (int i = 0; i < k; i++) e.mask[i] = 1'b1;
                    rem = FC;
                end else begin
                    for (int i = 0; i < n; i++) e.mask[i] = 1'b1;
                end
            end
            e.ff = (fv != 0) || e.rec;
            e.fb = (fv & BM) != 0;
            pf_acc  += int'(e.ff);
            pb_acc  += int'(e.fb);
            pfl_acc += int'(e.fl);
        end
        sbq.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("flush", 32'(flush), 32'(e.fl));
                if (e.fl || !rst_n) chk("excep_slot", 32'(excep_slot), 32'(e.slot));
                chk("commit_mask", 32'(commit_mask), 32'(e.mask));
                chk("freeze_front", 32'(freeze_front), 32'(e.ff));
                chk("freeze_back", 32'(freeze_back), 32'(e.fb));
                chk("recovering", 32'(recovering), 32'(e.rec));
`ifdef PIPE_CTRL_PERF_EN
                chk("perf_front_stall", perf_front_stall, e.pf);
                chk("perf_back_stall", perf_back_stall, e.pb);
                chk("perf_flush", perf_flush, e.pfl);
`endif
            end
        end
    end

    initial begin : driver
        logic [FN-1:0] fv;
        logic [RW-1:0] rd;
        logic [RW-1:0] ex;
        int            w;
        rst_n     = 1'b0;
        full_vec  = '0;
        ready_ret = '0;
        excep_ret = '0;
        repeat (3) step(0, '0, 3'b111, 3'b001);
        step(1, '0, 3'b111, 3'b001);
        repeat (2) step(1, '0, 3'b000, 3'b000);
        step(1, '0, 3'b011, 3'b000);
        step(1, '0, 3'b101, 3'b000);
        step(1, '0, 3'b111, 3'b110);
        repeat (2) step(1, '0, 3'b111, 3'b111);
        step(1, '0, 3'b101, 3'b100);
        repeat (7) step(1, '0, 3'b001, 3'b001);
        repeat (2) step(1, '0, 3'b000, 3'b000);
        step(1, '0, 3'b001, 3'b001);
        step(0, '0, 3'b001, 3'b001);
        step(1, '0, 3'b001, 3'b001);
        repeat (2) step(1, '0, 3'b000, 3'b000);
        step(1, 7'b0000100, 3'b000, 3'b000);
        step(0, '0, 3'b000, 3'b000);
        repeat (10) step(1, 7'b1000000, 3'b000, 3'b000);
        step(1, '0, 3'b000, 3'b000);
        for (int c = 0; c < 400; c++) begin
            fv = ($urandom_range(0, 3) == 0) ? FN'($urandom) : '0;
            rd = RW'($urandom);
            ex = ($urandom_range(0, 2) == 0) ? RW'($urandom) : '0;
            step($urandom_range(0, 39) != 0, fv, rd, ex);
        end
        w = 0;
        while (sbq.size() > 0 && w < 10) begin
            @(posedge clk);
            w++;
        end
        @(posedge clk);
        n_cmp++;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
